// File: rtl/load_store_buffer.sv
// In-order load/store queue feeding the cache data port.
// Stores and I/O loads wait for ROB commit; uncommitted entries are dropped on a flush.
module load_store_buffer #(
    parameter int LSB_WIDTH = 3,
    parameter int LSB_SIZE  = 2 ** LSB_WIDTH,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    input  logic                 clearIn,
    input  logic                 readyIn,
    input  logic                 enqueueValid,
    input  logic                 enqueueStore,
    input  logic [2:0]           enqueueFunct3,
    input  logic [31:0]          enqueueAddr,
    input  logic [31:0]          enqueueData,
    input  logic [ROB_WIDTH-1:0] enqueueRobIndex,
    output logic                 full,
    input  logic                 commitValid,
    input  logic [ROB_WIDTH-1:0] commitRobIndex,
    output logic [1:0]           accessType,
    output logic                 readWriteOut,
    output logic [31:0]          dataAddrOut,
    output logic [31:0]          dataOut,
    input  logic                 dataInValid,
    input  logic [31:0]          dataIn,
    input  logic                 dataWriteSuc,
    output logic                 resultValid,
    output logic [ROB_WIDTH-1:0] resultRobIndex,
    output logic [31:0]          resultValue
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsbState_t;

    lsbState_t state, stateNext;

    logic                 entStore  [LSB_SIZE];
    logic [2:0]           entFunct3 [LSB_SIZE];
    logic [31:0]          entAddr   [LSB_SIZE];
    logic [31:0]          entData   [LSB_SIZE];
    logic [ROB_WIDTH-1:0] entRob    [LSB_SIZE];
    logic [LSB_SIZE-1:0]  committed;

    logic [LSB_WIDTH-1:0] head, tail;
    logic [LSB_WIDTH:0]   count, committedCount;

    logic                 enqAccept, enqCommit;
    logic [LSB_SIZE-1:0]  commitHit;
    logic [LSB_WIDTH:0]   newCommits;
    logic [LSB_WIDTH-1:0] offset;
    logic                 headStore, headCommitted, headEligible;
    logic [2:0]           headFunct3;
    logic                 issue, killReq, deq, resultFire, deqCommitted;
    logic [31:0]          loadValue;

    assign full = (count == (LSB_WIDTH+1)'(LSB_SIZE));

    assign headStore     = entStore[head];
    assign headFunct3    = entFunct3[head];
    assign headCommitted = committed[head];
    assign headEligible  = (count != '0) &&
                           ((!headStore && (entAddr[head][17:16] != 2'b11)) || headCommitted);

    // Commits and enqueues are ignored during a flush.
    assign enqAccept = enqueueValid && !full && readyIn && !clearIn;
    assign enqCommit = enqAccept && commitValid && (enqueueRobIndex == commitRobIndex);

    always_comb begin
        newCommits = '0;
        offset     = '0;
        commitHit  = '0;
        for (int unsigned i = 0; i < LSB_SIZE; i++) begin
            offset       = LSB_WIDTH'(i) - head;
            commitHit[i] = commitValid && readyIn && !clearIn && !committed[i] &&
                           ({1'b0, offset} < count) && (entRob[i] == commitRobIndex);
            newCommits   = newCommits + (LSB_WIDTH+1)'(commitHit[i]);
        end
        newCommits = newCommits + (LSB_WIDTH+1)'(enqCommit);
    end

    always_comb begin
        case (headFunct3)
            3'b000:  loadValue = {{24{dataIn[7]}}, dataIn[7:0]};
            3'b001:  loadValue = {{16{dataIn[15]}}, dataIn[15:0]};
            3'b100:  loadValue = {24'b0, dataIn[7:0]};
            3'b101:  loadValue = {16'b0, dataIn[15:0]};
            default: loadValue = dataIn;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        issue      = 1'b0;
        killReq    = 1'b0;
        deq        = 1'b0;
        resultFire = 1'b0;
        if (readyIn) begin
            case (state)
                IDLE: begin
                    if (headEligible && (!clearIn || headCommitted)) begin
                        issue     = 1'b1;
                        stateNext = REQ;
                    end
                end
                REQ: begin
                    killReq   = 1'b1;
                    stateNext = (clearIn && !headCommitted) ? IDLE : WAIT;
                end
                WAIT: begin
                    if (clearIn && !headCommitted) begin
                        stateNext = IDLE;
                    end else if (headStore) begin
                        if (dataWriteSuc) begin
                            deq       = 1'b1;
                            stateNext = IDLE;
                        end
                    end else if (dataInValid) begin
                        deq        = 1'b1;
                        resultFire = 1'b1;
                        stateNext  = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign deqCommitted = deq && headCommitted;

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            committedCount <= '0;
            committed      <= '0;
            accessType     <= '0;
            readWriteOut   <= 1'b1;
            dataAddrOut    <= '0;
            dataOut        <= '0;
            resultValid    <= 1'b0;
            resultRobIndex <= '0;
            resultValue    <= '0;
        end else if (readyIn) begin
            resultValid <= resultFire;
            if (resultFire) begin
                resultRobIndex <= entRob[head];
                resultValue    <= loadValue;
            end
            if (issue) begin
                accessType   <= headFunct3[1:0] + 2'd1;
                readWriteOut <= !headStore;
                dataAddrOut  <= entAddr[head];
                dataOut      <= entData[head];
            end
            if (killReq) accessType <= '0;

            if (enqAccept) begin
                entStore[tail]  <= enqueueStore;
                entFunct3[tail] <= enqueueFunct3;
                entAddr[tail]   <= enqueueAddr;
                entData[tail]   <= enqueueData;
                entRob[tail]    <= enqueueRobIndex;
                committed[tail] <= enqCommit;
            end
            for (int unsigned i = 0; i < LSB_SIZE; i++) begin
                if (commitHit[i]) committed[i] <= 1'b1;
            end
            if (deq) begin
                committed[head] <= 1'b0;
                head            <= head + 1'b1;
            end

            // Only a committed op can dequeue during a flush, so the old
            // head + committedCount still marks the end of the kept entries.
            if (clearIn) begin
                tail           <= head + committedCount[LSB_WIDTH-1:0];
                count          <= committedCount - (LSB_WIDTH+1)'(deqCommitted);
                committedCount <= committedCount - (LSB_WIDTH+1)'(deqCommitted);
            end else begin
                tail           <= tail + LSB_WIDTH'(enqAccept);
                count          <= count + (LSB_WIDTH+1)'(enqAccept) - (LSB_WIDTH+1)'(deq);
                committedCount <= committedCount + newCommits - (LSB_WIDTH+1)'(deqCommitted);
            end
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer with hand-computed expected values.
module tb_load_store_buffer;

    localparam int LSB_WIDTH = 3;
    localparam int LSB_SIZE  = 8;
    localparam int ROB_WIDTH = 4;

    logic                 clkIn = 1'b0;
    logic                 resetIn, clearIn, readyIn;
    logic                 enqueueValid, enqueueStore;
    logic [2:0]           enqueueFunct3;
    logic [31:0]          enqueueAddr, enqueueData;
    logic [ROB_WIDTH-1:0] enqueueRobIndex;
    logic                 full;
    logic                 commitValid;
    logic [ROB_WIDTH-1:0] commitRobIndex;
    logic [1:0]           accessType;
    logic                 readWriteOut;
    logic [31:0]          dataAddrOut, dataOut;
    logic                 dataInValid;
    logic [31:0]          dataIn;
    logic                 dataWriteSuc;
    logic                 resultValid;
    logic [ROB_WIDTH-1:0] resultRobIndex;
    logic [31:0]          resultValue;

    int vecCount = 0;
    int errCount = 0;
    int cyc;

    load_store_buffer #(.LSB_WIDTH(LSB_WIDTH), .LSB_SIZE(LSB_SIZE), .ROB_WIDTH(ROB_WIDTH)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .readyIn(readyIn),
        .enqueueValid(enqueueValid), .enqueueStore(enqueueStore), .enqueueFunct3(enqueueFunct3),
        .enqueueAddr(enqueueAddr), .enqueueData(enqueueData), .enqueueRobIndex(enqueueRobIndex),
        .full(full), .commitValid(commitValid), .commitRobIndex(commitRobIndex),
        .accessType(accessType), .readWriteOut(readWriteOut), .dataAddrOut(dataAddrOut),
        .dataOut(dataOut), .dataInValid(dataInValid), .dataIn(dataIn), .dataWriteSuc(dataWriteSuc),
        .resultValid(resultValid), .resultRobIndex(resultRobIndex), .resultValue(resultValue)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clkIn);
        #1;
    endtask

    task automatic enqueue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] rob);
        enqueueValid = 1'b1; enqueueStore = st; enqueueFunct3 = f3;
        enqueueAddr = a; enqueueData = d; enqueueRobIndex = rob;
        tick;
        enqueueValid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] rob);
        commitValid = 1'b1; commitRobIndex = rob;
        tick;
        commitValid = 1'b0;
    endtask

    // Bounded wait for a request to appear on accessType.
    task automatic waitReq(output int cycles);
        cycles = 0;
        while (accessType == 2'b00 && cycles < 20) begin
            tick;
            cycles++;
        end
    endtask

    task automatic issueCheck(input string tag, input logic [1:0] at, input logic rw,
                              input logic [31:0] a, input logic [31:0] d);
        int c;
        waitReq(c);
        checkVal({tag, ".type"}, {30'b0, accessType}, {30'b0, at});
        checkVal({tag, ".rw"}, {31'b0, readWriteOut}, {31'b0, rw});
        checkVal({tag, ".addr"}, dataAddrOut, a);
        if (!rw) checkVal({tag, ".data"}, dataOut, d);
        tick;
        checkVal({tag, ".oneShot"}, {30'b0, accessType}, 32'd0);
    endtask

    task automatic loadReturn(input string tag, input logic [31:0] din,
                              input logic [3:0] rob, input logic [31:0] val);
        dataInValid = 1'b1; dataIn = din;
        tick;
        dataInValid = 1'b0;
        checkVal({tag, ".valid"}, {31'b0, resultValid}, 32'd1);
        checkVal({tag, ".rob"}, {28'b0, resultRobIndex}, {28'b0, rob});
        checkVal({tag, ".value"}, resultValue, val);
        tick;
        checkVal({tag, ".pulse"}, {31'b0, resultValid}, 32'd0);
    endtask

    task automatic storeDone;
        dataWriteSuc = 1'b1;
        tick;
        dataWriteSuc = 1'b0;
    endtask

    initial begin
        resetIn = 1'b0; clearIn = 1'b0; readyIn = 1'b1;
        enqueueValid = 1'b0; enqueueStore = 1'b0; enqueueFunct3 = 3'b000;
        enqueueAddr = '0; enqueueData = '0; enqueueRobIndex = '0;
        commitValid = 1'b0; commitRobIndex = '0;
        dataInValid = 1'b0; dataIn = '0; dataWriteSuc = 1'b0;
        repeat (3) tick;
        checkVal("rst.accessType", {30'b0, accessType}, 32'd0);
        checkVal("rst.readWrite", {31'b0, readWriteOut}, 32'd1);
        checkVal("rst.addr", dataAddrOut, 32'd0);
        checkVal("rst.resultValid", {31'b0, resultValid}, 32'd0);
        checkVal("rst.full", {31'b0, full}, 32'd0);
        resetIn = 1'b1;
        tick;

        // LW with one-cycle issue latency, and a readyIn freeze while in REQ
        enqueue(1'b0, 3'b010, 32'h100, 32'h0, 4'd5);
        waitReq(cyc);
        checkVal("lw.latency", cyc, 32'd1);
        checkVal("lw.type", {30'b0, accessType}, 32'd3);
        checkVal("lw.rw", {31'b0, readWriteOut}, 32'd1);
        checkVal("lw.addr", dataAddrOut, 32'h100);
        readyIn = 1'b0;
        tick; tick;
        checkVal("lw.frozen", {30'b0, accessType}, 32'd3);
        readyIn = 1'b1;
        tick;
        checkVal("lw.oneShot", {30'b0, accessType}, 32'd0);
        loadReturn("lw", 32'h8000_00F0, 4'd5, 32'h8000_00F0);

        // LB with resultValid held under readyIn=0
        enqueue(1'b0, 3'b000, 32'h3, 32'h0, 4'd1);
        issueCheck("lb", 2'b01, 1'b1, 32'h3, 32'h0);
        dataInValid = 1'b1; dataIn = 32'h0000_0080;
        tick;
        dataInValid = 1'b0;
        checkVal("lb.value", resultValue, 32'hFFFF_FF80);
        readyIn = 1'b0;
        tick;
        checkVal("lb.held", {31'b0, resultValid}, 32'd1);
        readyIn = 1'b1;
        tick;
        checkVal("lb.pulse", {31'b0, resultValid}, 32'd0);

        enqueue(1'b0, 3'b100, 32'h3, 32'h0, 4'd2);
        issueCheck("lbu", 2'b01, 1'b1, 32'h3, 32'h0);
        loadReturn("lbu", 32'hABCD_EF80, 4'd2, 32'h0000_0080);
        enqueue(1'b0, 3'b001, 32'h2, 32'h0, 4'd3);
        issueCheck("lh", 2'b10, 1'b1, 32'h2, 32'h0);
        loadReturn("lh", 32'h0000_8001, 4'd3, 32'hFFFF_8001);
        enqueue(1'b0, 3'b101, 32'h2, 32'h0, 4'd4);
        issueCheck("lhu", 2'b10, 1'b1, 32'h2, 32'h0);
        loadReturn("lhu", 32'hFFFF_8001, 4'd4, 32'h0000_8001);

        // Store waits for commit and blocks the younger load
        enqueue(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 4'd2);
        enqueue(1'b0, 3'b010, 32'h204, 32'h0, 4'd3);
        repeat (4) tick;
        checkVal("sw.held", {30'b0, accessType}, 32'd0);
        commit(4'd2);
        issueCheck("sw", 2'b11, 1'b0, 32'h200, 32'hDEAD_BEEF);
        tick; tick;
        checkVal("sw.order", {30'b0, accessType}, 32'd0);
        storeDone;
        issueCheck("swLoad", 2'b11, 1'b1, 32'h204, 32'h0);
        loadReturn("swLoad", 32'h1234_5678, 4'd3, 32'h1234_5678);

        // I/O-region load waits for commit
        enqueue(1'b0, 3'b010, 32'h3_0000, 32'h0, 4'd7);
        repeat (3) tick;
        checkVal("io.held", {30'b0, accessType}, 32'd0);
        commit(4'd7);
        issueCheck("io", 2'b11, 1'b1, 32'h3_0000, 32'h0);
        loadReturn("io", 32'hCAFE_0001, 4'd7, 32'hCAFE_0001);

        // Fill, drop an extra enqueue, then wrap past the last slot
        for (int i = 0; i < LSB_SIZE; i++) begin
            checkVal("fill.notFull", {31'b0, full}, 32'd0);
            enqueue(1'b1, 3'b010, 32'h1000 + 32'(4 * i), 32'(i), 4'(i));
        end
        checkVal("fill.full", {31'b0, full}, 32'd1);
        enqueue(1'b1, 3'b010, 32'hBAD0, 32'hBAD, 4'd15);
        checkVal("fill.stillFull", {31'b0, full}, 32'd1);
        commit(4'd0);
        issueCheck("wrap0", 2'b11, 1'b0, 32'h1000, 32'd0);
        storeDone;
        checkVal("wrap.notFull", {31'b0, full}, 32'd0);
        enqueue(1'b1, 3'b010, 32'h2000, 32'd8, 4'd8);
        checkVal("wrap.fullAgain", {31'b0, full}, 32'd1);
        for (int i = 1; i <= LSB_SIZE; i++) begin
            commit(4'(i));
            issueCheck("wrap", 2'b11, 1'b0, (i == LSB_SIZE) ? 32'h2000 : 32'h1000 + 32'(4 * i), 32'(i));
            storeDone;
        end
        checkVal("wrap.empty", {31'b0, full}, 32'd0);

        // Flush with two committed stores ahead of two uncommitted loads
        enqueue(1'b1, 3'b000, 32'h300, 32'h0000_00AA, 4'd1);
        enqueue(1'b1, 3'b001, 32'h302, 32'h0000_BBBB, 4'd2);
        enqueue(1'b0, 3'b010, 32'h400, 32'h0, 4'd3);
        enqueue(1'b0, 3'b001, 32'h404, 32'h0, 4'd4);
        commit(4'd1);
        commit(4'd2);
        issueCheck("clrSb", 2'b01, 1'b0, 32'h300, 32'h0000_00AA);
        clearIn = 1'b1;
        enqueueValid = 1'b1; enqueueStore = 1'b0; enqueueFunct3 = 3'b010;
        enqueueAddr = 32'h800; enqueueRobIndex = 4'd12;
        tick;
        clearIn = 1'b0; enqueueValid = 1'b0;
        checkVal("clr.resultValid", {31'b0, resultValid}, 32'd0);
        storeDone;
        issueCheck("clrSh", 2'b10, 1'b0, 32'h302, 32'h0000_BBBB);
        storeDone;
        repeat (4) tick;
        checkVal("clr.dropped", {30'b0, accessType}, 32'd0);
        checkVal("clr.noResult", {31'b0, resultValid}, 32'd0);
        enqueue(1'b0, 3'b010, 32'h500, 32'h0, 4'd9);
        issueCheck("clrNext", 2'b11, 1'b1, 32'h500, 32'h0);
        loadReturn("clrNext", 32'h0000_0055, 4'd9, 32'h0000_0055);

        // Flush aborts an uncommitted load in WAIT, even with data arriving
        enqueue(1'b0, 3'b010, 32'h600, 32'h0, 4'd10);
        issueCheck("abort", 2'b11, 1'b1, 32'h600, 32'h0);
        clearIn = 1'b1; dataInValid = 1'b1; dataIn = 32'h6666_6666;
        tick;
        clearIn = 1'b0; dataInValid = 1'b0;
        checkVal("abort.noResult", {31'b0, resultValid}, 32'd0);
        checkVal("abort.type", {30'b0, accessType}, 32'd0);
        tick;
        checkVal("abort.noReissue", {30'b0, accessType}, 32'd0);
        enqueue(1'b0, 3'b010, 32'h700, 32'h0, 4'd11);
        issueCheck("afterAbort", 2'b11, 1'b1, 32'h700, 32'h0);
        loadReturn("afterAbort", 32'h0000_7777, 4'd11, 32'h0000_7777);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
